// File: rtl/final_exam_pkg.sv
// Shared types and constants for the final_exam signature stage.
package final_exam_pkg;

  localparam int unsigned SIG_W = 16;
  localparam int unsigned OBS_W = 8;

  localparam logic [SIG_W-1:0] DEFAULT_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One MISR step: shift left, fold the polynomial on carry-out, inject the sample.
  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0] sig,
    input logic [SIG_W-1:0] poly,
    input logic [OBS_W-1:0] din
  );
    logic [SIG_W-1:0] w_fb;
    w_fb = sig[SIG_W-1] ? poly : '0;
    return {sig[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-OBS_W){1'b0}}, din};
  endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; load has priority over the shift enable.
module misr16
  import final_exam_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SIG_W-1:0] init,
  input  logic             en,
  input  logic [OBS_W-1:0] din,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= init;
    end else if (en) begin
      r_sig <= misr_next(r_sig, POLY, din);
    end
  end

  assign q = r_sig;

endmodule

// File: rtl/signature_compactor.sv
// Compacts seed-scrambled observation words into a MISR signature over a
// fixed window after a warm-up skip, then reports pass/fail against a golden value.
module signature_compactor
  import final_exam_pkg::*;
#(
  parameter int unsigned      WINDOW = 255,
  parameter int unsigned      SKIP   = 16,
  parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY,
  parameter logic [SIG_W-1:0] INIT   = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [OBS_W-1:0] seed,
  input  logic [OBS_W-1:0] obs,
  input  logic [SIG_W-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [7:0]       sample_count
);

  localparam logic [7:0] LP_WINDOW = 8'(WINDOW);
  localparam logic [7:0] LP_SKIP   = 8'(SKIP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_skip_cnt;
  logic [7:0]       w_skip_nxt;
  logic [7:0]       r_sample_cnt;
  logic [7:0]       w_sample_nxt;
  logic [7:0]       w_sample_inc;
  logic             r_busy;
  logic             r_done;
  logic             w_misr_load;
  logic             w_misr_en;
  logic [OBS_W-1:0] w_sample;
  logic [SIG_W-1:0] w_sig;

  assign w_sample     = obs ^ seed;
  assign w_sample_inc = r_sample_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_skip_cnt   <= '0;
      r_sample_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_skip_cnt   <= w_skip_nxt;
      r_sample_cnt <= w_sample_nxt;
      r_busy       <= (w_state_nxt == ARM) || (w_state_nxt == RUN);
      r_done       <= (w_state_nxt == DONE);
    end
  end

  // start overrides everything, including the sample that would finish the window.
  always_comb begin
    w_state_nxt  = r_state;
    w_skip_nxt   = r_skip_cnt;
    w_sample_nxt = r_sample_cnt;
    w_misr_load  = 1'b0;
    w_misr_en    = 1'b0;
    if (start) begin
      w_state_nxt  = ARM;
      w_skip_nxt   = '0;
      w_sample_nxt = '0;
      w_misr_load  = 1'b1;
    end else begin
      unique case (r_state)
        ARM: begin
          if (!hold) begin
            if (r_skip_cnt == LP_SKIP) begin
              w_state_nxt = RUN;
            end else begin
              w_skip_nxt = r_skip_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          if (!hold) begin
            w_misr_en    = 1'b1;
            w_sample_nxt = w_sample_inc;
            if (w_sample_inc == LP_WINDOW) begin
              w_state_nxt = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  misr16 #(
    .POLY(POLY)
  ) u_misr (
    .clk  (clk),
    .reset(reset),
    .load (w_misr_load),
    .init (INIT),
    .en   (w_misr_en),
    .din  (w_sample),
    .q    (w_sig)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_done && (w_sig == expected);
  assign signature    = w_sig;
  assign sample_count = r_sample_cnt;

endmodule

// File: tb/tb_signature_compactor.sv
// Self-checking bench: five differently parameterised compactors share one
// stimulus stream and are compared each cycle against a window/skip model.
module tb_signature_compactor;

  localparam int NI = 5;
  localparam int          M_W    [NI] = '{1, 2, 4, 1, 255};
  localparam int          M_S    [NI] = '{0, 0, 16, 0, 16};
  localparam logic [15:0] M_INIT [NI] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000};

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic        hold     = 1'b0;
  logic [7:0]  seed     = 8'h00;
  logic [7:0]  obs      = 8'h00;
  logic [15:0] expected = 16'h0000;

  logic        o_busy  [NI];
  logic        o_done  [NI];
  logic        o_pass  [NI];
  logic [15:0] o_sig   [NI];
  logic [7:0]  o_cnt   [NI];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: samples are counted after SKIP+1 unheld arming cycles.
  bit          m_act [NI];
  int          m_t   [NI];
  int          m_cnt [NI];
  logic [15:0] m_sig [NI];

  initial for (int i = 0; i < NI; i++) begin
    m_act[i] = 1'b0; m_t[i] = 0; m_cnt[i] = 0; m_sig[i] = 16'h0000;
  end

  always #5 clk = ~clk;

  signature_compactor #(.WINDOW(1), .SKIP(0), .POLY(16'h1021), .INIT(16'h0000)) u0 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .seed(seed), .obs(obs),
    .expected(expected), .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]),
    .signature(o_sig[0]), .sample_count(o_cnt[0]));
  signature_compactor #(.WINDOW(2), .SKIP(0), .POLY(16'h1021), .INIT(16'h0000)) u1 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .seed(seed), .obs(obs),
    .expected(expected), .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]),
    .signature(o_sig[1]), .sample_count(o_cnt[1]));
  signature_compactor #(.WINDOW(4), .SKIP(16), .POLY(16'h1021), .INIT(16'h0000)) u2 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .seed(seed), .obs(obs),
    .expected(expected), .busy(o_busy[2]), .done(o_done[2]), .pass(o_pass[2]),
    .signature(o_sig[2]), .sample_count(o_cnt[2]));
  signature_compactor #(.WINDOW(1), .SKIP(0), .POLY(16'h1021), .INIT(16'h8000)) u3 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .seed(seed), .obs(obs),
    .expected(expected), .busy(o_busy[3]), .done(o_done[3]), .pass(o_pass[3]),
    .signature(o_sig[3]), .sample_count(o_cnt[3]));
  signature_compactor #(.WINDOW(255), .SKIP(16), .POLY(16'h1021), .INIT(16'h0000)) u4 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .seed(seed), .obs(obs),
    .expected(expected), .busy(o_busy[4]), .done(o_done[4]), .pass(o_pass[4]),
    .signature(o_sig[4]), .sample_count(o_cnt[4]));

  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [7:0] d);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {8'h00, d};
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_cnt[i] <= 0; m_sig[i] <= 16'h0000;
      end else if (start) begin
        m_act[i] <= 1'b1; m_t[i] <= 0; m_cnt[i] <= 0; m_sig[i] <= M_INIT[i];
      end else if (m_act[i] && !hold && m_cnt[i] < M_W[i]) begin
        if (m_t[i] <= M_S[i]) begin
          m_t[i] <= m_t[i] + 1;
        end else begin
          m_sig[i] <= model_step(m_sig[i], obs ^ seed);
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic e_done;
        e_done = m_act[i] && (m_cnt[i] == M_W[i]);
        chk($sformatf("u%0d busy", i), 32'(o_busy[i]), 32'(m_act[i] && (m_cnt[i] < M_W[i])));
        chk($sformatf("u%0d done", i), 32'(o_done[i]), 32'(e_done));
        chk($sformatf("u%0d pass", i), 32'(o_pass[i]), 32'(e_done && (m_sig[i] == expected)));
        chk($sformatf("u%0d signature", i), 32'(o_sig[i]), 32'(m_sig[i]));
        chk($sformatf("u%0d sample_count", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    step(); step();
    chk_en = 1'b1;
    reset = 1'b1;
    step();

    // WINDOW=1 SKIP=0: done exactly two edges after the start edge.
    seed = 8'h00; obs = 8'h5A; expected = 16'h0000;
    pulse_start();
    step();
    chk("t1 done early", 32'(o_done[0]), 32'd0);
    step();
    chk("t1 done", 32'(o_done[0]), 32'd1);
    chk("t1 signature", 32'(o_sig[0]), 32'h005A);
    chk("t1 sample_count", 32'(o_cnt[0]), 32'd1);

    // Polynomial feedback from INIT=8000.
    obs = 8'h00;
    pulse_start();
    step(); step();
    chk("t6 done", 32'(o_done[3]), 32'd1);
    chk("t6 signature", 32'(o_sig[3]), 32'h1021);

    // WINDOW=2, then the same with a cancelling seed.
    for (int k = 0; k < 2; k++) begin
      seed = (k == 0) ? 8'h00 : 8'hFF;
      obs  = (k == 0) ? 8'h01 : 8'hFE;
      expected = 16'h0003;
      pulse_start();
      step(); step();
      chk($sformatf("t%0d sig1", k + 2), 32'(o_sig[1]), 32'h0001);
      chk($sformatf("t%0d done early", k + 2), 32'(o_done[1]), 32'd0);
      step();
      chk($sformatf("t%0d sig2", k + 2), 32'(o_sig[1]), 32'h0003);
      chk($sformatf("t%0d pass", k + 2), 32'(o_pass[1]), 32'd1);
    end

    // SKIP=16 WINDOW=4 with a 3-cycle hold after the first sample.
    seed = 8'h00; obs = 8'h01; expected = 16'h000F;
    pulse_start();
    repeat (18) step();
    chk("t4 first sample", 32'(o_sig[2]), 32'h0001);
    chk("t4 busy", 32'(o_busy[2]), 32'd1);
    hold = 1'b1;
    repeat (3) step();
    chk("t4 held sig", 32'(o_sig[2]), 32'h0001);
    chk("t4 held count", 32'(o_cnt[2]), 32'd1);
    hold = 1'b0;
    step();
    chk("t4 sig after hold", 32'(o_sig[2]), 32'h0003);
    step();
    chk("t4 done early", 32'(o_done[2]), 32'd0);
    step();
    chk("t4 done", 32'(o_done[2]), 32'd1);
    chk("t4 signature", 32'(o_sig[2]), 32'h000F);
    chk("t4 pass", 32'(o_pass[2]), 32'd1);

    // Async reset mid-run, then start colliding with a final sample.
    pulse_start();
    repeat (19) step();
    reset = 1'b0;
    #1;
    chk("t5 rst busy", 32'(o_busy[2]), 32'd0);
    chk("t5 rst done", 32'(o_done[0]), 32'd0);
    chk("t5 rst sig", 32'(o_sig[2]), 32'd0);
    chk("t5 rst count", 32'(o_cnt[2]), 32'd0);
    step();
    reset = 1'b1;
    step();
    pulse_start();
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5 collide done", 32'(o_done[1]), 32'd0);
    chk("t5 collide busy", 32'(o_busy[1]), 32'd1);
    chk("t5 collide count", 32'(o_cnt[1]), 32'd0);

    // Randomised traffic, including mid-cycle reset pulses.
    for (int c = 0; c < 6000; c++) begin
      start = (c == 0) || ($urandom_range(0, 349) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      obs   = 8'($urandom);
      if ($urandom_range(0, 63) == 0) seed = 8'($urandom);
      if ($urandom_range(0, 15) == 0) expected = m_sig[$urandom_range(0, NI - 1)];
      else if ($urandom_range(0, 63) == 0) expected = 16'($urandom);
      reset = ($urandom_range(0, 1999) != 0);
      step();
    end
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
